// File: rtl/shot_pkg.sv
// Shared types for the shot record FIFO: record layout, byte map, FSM states.
// SHOT_TIMESTAMP_EN adds a 16-bit millisecond timestamp field to each record.
package shot_pkg;

    localparam int SETTLE_CYC = 8;

    localparam logic [3:0] BYTE_NORTH_LO = 4'd0;
    localparam logic [3:0] BYTE_NORTH_HI = 4'd1;
    localparam logic [3:0] BYTE_SOUTH_LO = 4'd2;
    localparam logic [3:0] BYTE_SOUTH_HI = 4'd3;
    localparam logic [3:0] BYTE_EAST_LO  = 4'd4;
    localparam logic [3:0] BYTE_EAST_HI  = 4'd5;
    localparam logic [3:0] BYTE_WEST_LO  = 4'd6;
    localparam logic [3:0] BYTE_WEST_HI  = 4'd7;
    localparam logic [3:0] BYTE_STATUS   = 4'd8;
    localparam logic [3:0] BYTE_TS_LO    = 4'd9;
    localparam logic [3:0] BYTE_TS_HI    = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SETTLE,
        ST_CAPTURE
    } shot_state_e;

    typedef struct packed {
        logic [15:0] north;
        logic [15:0] south;
        logic [15:0] east;
        logic [15:0] west;
        logic [3:0]  seq;
        logic [3:0]  done_mask;
`ifdef SHOT_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } shot_rec_t;

    // Byte view of a record as firmware sees it through the register map.
    function automatic logic [7:0] rec_byte(input shot_rec_t r, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            BYTE_NORTH_LO: b = r.north[7:0];
            BYTE_NORTH_HI: b = r.north[15:8];
            BYTE_SOUTH_LO: b = r.south[7:0];
            BYTE_SOUTH_HI: b = r.south[15:8];
            BYTE_EAST_LO:  b = r.east[7:0];
            BYTE_EAST_HI:  b = r.east[15:8];
            BYTE_WEST_LO:  b = r.west[7:0];
            BYTE_WEST_HI:  b = r.west[15:8];
            BYTE_STATUS:   b = {r.seq, r.done_mask};
`ifdef SHOT_TIMESTAMP_EN
            BYTE_TS_LO:    b = r.ts[7:0];
            BYTE_TS_HI:    b = r.ts[15:8];
`endif
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/shot_fifo_mem.sv
// Register FIFO of shot records. Push when full and pop when empty are ignored;
// flush empties the FIFO and wins over a push or pop in the same cycle.
module shot_fifo_mem
    import shot_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk64M,
    input  logic             reset_n,
    input  logic             push,
    input  shot_rec_t        push_rec,
    input  logic             pop,
    input  logic             flush,
    output shot_rec_t        head_rec,
    output logic [PTR_W:0]   level,
    output logic             full,
    output logic             empty
);

    shot_rec_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (PTR_W + 1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_rec = mem[rd_ptr];

    // Storage needs no reset: the head is masked by empty downstream.
    always_ff @(posedge clk64M) begin
        if (do_push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/shot_record_fifo.sv
// Snapshots the four direction counts into a record FIFO once a shot completes.
// Define SHOT_TIMESTAMP_EN to stamp each record with a free-running ms counter.
module shot_record_fifo
    import shot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TIMEOUT_CYC = 524288,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk64M,
    input  logic             reset_n,
    input  logic [3:0]       run,
    input  logic [15:0]      count_north,
    input  logic [15:0]      count_south,
    input  logic [15:0]      count_east,
    input  logic [15:0]      count_west,
    input  logic             flush,
    input  logic [3:0]       rd_byte,
    input  logic             rd_pop,
    output logic [7:0]       rd_data,
    output logic [PTR_W:0]   fifo_level,
    output logic             shot_avail,
    output logic             overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam int SET_W = $clog2(SETTLE_CYC);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    logic [3:0]       run_q1, run_q2, run_q3;
    logic [3:0]       rise, fall;
    shot_state_e      state;
    logic [3:0]       done_mask, rose_mask, pend_mask, seq;
    logic [3:0]       done_nxt, rose_nxt, arm_mask;
    logic             all_fallen;
    logic [TMO_W-1:0] tmo_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             push;
    shot_rec_t        cap_rec;
    shot_rec_t        head_rec;
    logic             fifo_full, fifo_empty;

    // run comes from the clk8M domain; two flops then one more for edges.
    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            run_q1 <= '0;
            run_q2 <= '0;
            run_q3 <= '0;
        end else begin
            run_q1 <= run;
            run_q2 <= run_q1;
            run_q3 <= run_q2;
        end
    end

    assign rise       = run_q2 & ~run_q3;
    assign fall       = ~run_q2 & run_q3;
    assign done_nxt   = done_mask | fall;
    assign rose_nxt   = rose_mask | rise;
    assign all_fallen = ((rose_nxt & ~done_nxt) == 4'h0);
    // A rise that arrived while settling only counts if the channel is still high.
    assign arm_mask   = rise | (pend_mask & run_q2);

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            done_mask  <= '0;
            rose_mask  <= '0;
            pend_mask  <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
            seq        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pend_mask <= '0;
                    if (arm_mask != 4'h0) begin
                        state     <= ST_ARMED;
                        done_mask <= '0;
                        rose_mask <= arm_mask;
                        tmo_cnt   <= TMO_LOAD;
                    end
                end
                ST_ARMED: begin
                    done_mask <= done_nxt;
                    rose_mask <= rose_nxt;
                    if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                    if ((tmo_cnt == '0) || (all_fallen && (run_q2 == 4'h0))) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    pend_mask <= pend_mask | rise;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    pend_mask <= pend_mask | rise;
                    seq       <= seq + 4'd1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign push = (state == ST_CAPTURE);

`ifdef SHOT_TIMESTAMP_EN
    localparam logic [15:0] MS_PRESCALE_LAST = 16'd63999;
    logic [15:0] pre_cnt;
    logic [15:0] ms_cnt;

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (pre_cnt == MS_PRESCALE_LAST) begin
            pre_cnt <= '0;
            ms_cnt  <= ms_cnt + 16'd1;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        cap_rec           = '0;
        cap_rec.north     = count_north;
        cap_rec.south     = count_south;
        cap_rec.east      = count_east;
        cap_rec.west      = count_west;
        cap_rec.seq       = seq;
        cap_rec.done_mask = done_mask;
`ifdef SHOT_TIMESTAMP_EN
        cap_rec.ts        = ms_cnt;
`endif
    end

    shot_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk64M   (clk64M),
        .reset_n  (reset_n),
        .push     (push),
        .push_rec (cap_rec),
        .pop      (rd_pop),
        .flush    (flush),
        .head_rec (head_rec),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk64M or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    assign shot_avail = !fifo_empty;
    assign rd_data    = fifo_empty ? 8'h00 : rec_byte(head_rec, rd_byte);

endmodule
